if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Decoupling buffer between the fetch stage and the decode stage.
- Captures each fetched {PC+4, instruction} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Back-pressures fetch through the PC write enable and discards all queued entries when the branch predictor signals a mispredict flush.
- Tags branch opcodes so decode gets the branch flag without re-decoding.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DW, 32, width of the PC+4 and instruction fields.

Ports:
- CLK  in  1  clock; one clock, all state updates on posedge CLK.
- RST_N  in  1  reset; asynchronous and active-low.
- IN_VALID  in  1  fetch slot holds a valid instruction this cycle.
- PC_4_IN  in  DW  PC+4 of the fetched instruction.
- INSTR_IN  in  DW  fetched instruction word.
- FLUSH  in  1  mispredict flush from the branch predictor.
- OUT_READY  in  1  decode accepts the head entry this cycle.
- PC_WE  out  1  PC enable to fetch; high when the queue is not full.
- OUT_VALID  out  1  head entry is valid.
- PC_4_OUT  out  DW  head entry PC+4.
- INSTR_OUT  out  DW  head entry instruction.
- IS_BR_OUT  out  1  head entry opcode INSTR[31:26] is 101000 or 101001.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.
- DISCARD_CNT  out  16  saturating count of flushes that discarded at least one entry.

Behaviour:
- Reset (RST_N low, asynchronous): read pointer, write pointer and COUNT go to 0; DISCARD_CNT goes to 0; all storage entries clear to 0.
- Outputs during reset: OUT_VALID=0, PC_4_OUT=0, INSTR_OUT=0, IS_BR_OUT=0, PC_WE=1.
- Reset asserted mid-operation discards every queued entry immediately, with no handshake completing.
- Write: occurs at posedge when IN_VALID && PC_WE && !FLUSH. Stores {PC_4_IN, INSTR_IN, branch tag}, where the branch tag is computed from INSTR_IN[31:26] at write time. Write pointer increments modulo DEPTH.
- Read: occurs at posedge when OUT_VALID && OUT_READY && !FLUSH. Read pointer increments modulo DEPTH.
- COUNT changes by +1 on write only, -1 on read only, and is unchanged on a simultaneous read and write.
- Write latency: an entry written at edge N is visible on the outputs after edge N. There is no same-cycle bypass from IN to OUT.
- OUT_VALID = (COUNT != 0).
- Head outputs: when empty, PC_4_OUT=0, INSTR_OUT=0 (NOP) and IS_BR_OUT=0. When not empty, they show the entry at the read pointer.
- PC_WE = (COUNT != DEPTH). It is purely a function of registered state, with no combinational path from OUT_READY.
- Full: PC_WE=0 and IN_VALID is ignored, even if a read occurs in the same cycle. The freed slot is writable from the next cycle.
- Empty: OUT_READY is ignored and COUNT does not underflow.
- Flush: synchronous, takes effect at posedge with FLUSH=1.
  - Pointers and COUNT go to 0.
  - Any write or read in that cycle is cancelled.
  - Stored data need not be cleared, but the outputs follow the empty rule from the next cycle.
  - If COUNT was nonzero before the flush, DISCARD_CNT increments, saturating at 0xFFFF.
- Flush and RST_N low together: reset wins.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. Full and empty are distinguished by COUNT, not by pointer equality.
- Ordering: strict FIFO order is preserved across wrap.

Test Plan:
- Reset then idle: RST_N low mid-cycle -> outputs zero immediately. After release with IN_VALID=0 -> OUT_VALID=0, PC_WE=1, COUNT=0.
- Fill to full: write 4 entries, OUT_READY=0, INSTR 0x00000001..0x00000004 -> COUNT=4, PC_WE=0, a fifth write with INSTR 0x00000005 is dropped. Draining gives 1,2,3,4 in order, then OUT_VALID=0.
- Simultaneous read/write at COUNT=2 over 10 cycles, covering pointer wrap -> COUNT stays 2 and output order matches input order exactly.
- Branch tag: write INSTR=0xA0000000 (opcode 101000) and 0xA4000010 (opcode 101001) -> IS_BR_OUT=1 for both. Write 0x8C000000 -> IS_BR_OUT=0.
- Flush with COUNT=3 while IN_VALID=1 -> next cycle COUNT=0, OUT_VALID=0, the incoming entry is dropped, DISCARD_CNT=1. A second flush while empty leaves DISCARD_CNT=1.
- Flush coincident with full and OUT_READY=1 -> COUNT=0, no read completes, PC_WE=1 on the next cycle.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch-to-decode decoupling FIFO that tags branch opcodes and empties on a mispredict flush.
// Latency: an entry written at edge N is presented to decode after edge N; there is no IN-to-OUT bypass.
// Backpressure: pc_we drops while full and comes from registered occupancy only (no path from out_ready).
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid, pc_4_in, instr_in  fetched {PC+4, instruction} slot
//   flush                        mispredict flush; empties the queue at the next edge
//   out_ready                    decode accepts the head entry
//   pc_we                        fetch PC enable (queue not full)
//   out_valid, pc_4_out, instr_out, is_br_out   head entry; all zero while empty
//   count                        current occupancy
//   discard_cnt                  saturating count of flushes that dropped at least one entry

// fifo: generic circular FIFO with synchronous flush and occupancy-based full/empty.
// Latency: a write at edge N is readable after edge N; the read port shows zero while empty.
// Backpressure: writes are refused while full, even when a read frees a slot in the same cycle.
module fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;

  // Pointers alone cannot tell full from empty; occupancy decides both.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Full blocks the write outright, so a slot freed by a same-cycle read is only writable next cycle.
  assign wr_fire = wr_vld && !full && !flush;
  assign rd_fire = rd_rdy && !empty && !flush;
  // Empty head reads as zero so decode sees a NOP rather than stale data left behind by a flush.
  assign rd_dat  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Stored data is left in place; the zeroed count hides it.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_fire && !rd_fire) begin
        count <= count + 1'b1;
      end else if (rd_fire && !wr_fire) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DW-1:0]          pc_4_in,
  input  logic [DW-1:0]          instr_in,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic                   pc_we,
  output logic                   out_valid,
  output logic [DW-1:0]          pc_4_out,
  output logic [DW-1:0]          instr_out,
  output logic                   is_br_out,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            discard_cnt
);
  typedef struct packed {
    logic [DW-1:0] pc_4;
    logic [DW-1:0] instr;
    logic          is_br;
  } entry_t;

  entry_t wr_ent;
  entry_t head;
  logic   full;
  logic   empty;

  // Branch opcodes 101000 and 101001 share the top five bits, so bit 26 is a don't-care.
  always_comb begin
    wr_ent       = '0;
    wr_ent.pc_4  = pc_4_in;
    wr_ent.instr = instr_in;
    wr_ent.is_br = (instr_in[31:27] == 5'b10100);
  end

  fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .wr_vld (in_valid),
    .wr_dat (wr_ent),
    .rd_rdy (out_ready),
    .rd_dat (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign pc_we     = !full;
  assign out_valid = !empty;
  assign pc_4_out  = head.pc_4;
  assign instr_out = head.instr;
  assign is_br_out = head.is_br;

  // Only flushes that actually threw work away are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt <= '0;
    end else if (flush && !empty && (discard_cnt != 16'hFFFF)) begin
      discard_cnt <= discard_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] pc_4_in;
  logic [31:0] instr_in;
  logic        flush;
  logic        out_ready;
  logic        pc_we;
  logic        out_valid;
  logic [31:0] pc_4_out;
  logic [31:0] instr_out;
  logic        is_br_out;
  logic [2:0]  count;
  logic [15:0] discard_cnt;

  if_fetch_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .pc_4_in     (pc_4_in),
    .instr_in    (instr_in),
    .flush       (flush),
    .out_ready   (out_ready),
    .pc_we       (pc_we),
    .out_valid   (out_valid),
    .pc_4_out    (pc_4_out),
    .instr_out   (instr_out),
    .is_br_out   (is_br_out),
    .count       (count),
    .discard_cnt (discard_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the queue contents as plain entries, plus the flush counter.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t mdl_q[$];
  int   mdl_disc;
  int   n_chk;
  int   n_fail;

  function automatic logic is_branch(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return (op == 6'b101000) || (op == 6'b101001);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int was_full;
    if (!rst_n) begin
      mdl_q.delete();
      mdl_disc = 0;
    end else if (flush) begin
      if (mdl_q.size() != 0 && mdl_disc < 65535) mdl_disc = mdl_disc + 1;
      mdl_q.delete();
    end else begin
      was_full = (mdl_q.size() == DEPTH) ? 1 : 0;
      if (out_ready && mdl_q.size() != 0) void'(mdl_q.pop_front());
      if (in_valid && was_full == 0) mdl_q.push_back('{pc_4_in, instr_in});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the presented head and status are compared with the model.
  task automatic monitor();
    ent_t h;
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(mdl_q.size() != 0));
      chk("pc_we", 32'(pc_we), 32'(mdl_q.size() != DEPTH));
      chk("count", 32'(count), 32'(mdl_q.size()));
      chk("discard_cnt", 32'(discard_cnt), 32'(mdl_disc));
      if (mdl_q.size() != 0) begin
        h = mdl_q[0];
        chk("pc_4_out", pc_4_out, h.pc);
        chk("instr_out", instr_out, h.ins);
        chk("is_br_out", 32'(is_br_out), 32'(is_branch(h.ins)));
      end else begin
        chk("pc_4_out_empty", pc_4_out, 32'h0);
        chk("instr_out_empty", instr_out, 32'h0);
        chk("is_br_out_empty", 32'(is_br_out), 32'h0);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic rdy, input logic fl);
    in_valid  = v;
    pc_4_in   = pc;
    instr_in  = ins;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    pc_4_in   = '0;
    instr_in  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_pc_we", 32'(pc_we), 32'h1);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("idle_count", 32'(count), 32'h0);

    // Fill to full; the fifth write must be dropped.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h1014, 32'h5, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'h4);
    chk("full_pc_we", 32'(pc_we), 32'h0);
    chk("full_head", instr_out, 32'h1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drained_valid", 32'(out_valid), 32'h0);

    // Steady read+write at occupancy 2 across pointer wrap.
    cyc(1'b1, 32'h2004, 32'h100, 1'b0, 1'b0);
    cyc(1'b1, 32'h2008, 32'h101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h200c + 32'(4 * i), 32'h102 + 32'(i), 1'b1, 1'b0);
    chk("steady_count", 32'(count), 32'h2);
    chk("steady_head", instr_out, 32'h10a);

    // Branch tagging.
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 32'h3004, 32'hA000_0000, 1'b0, 1'b0);
    chk("br_101000", 32'(is_br_out), 32'h1);
    cyc(1'b1, 32'h3008, 32'hA400_0010, 1'b1, 1'b0);
    chk("br_101001", 32'(is_br_out), 32'h1);
    cyc(1'b1, 32'h300c, 32'h8C00_0000, 1'b1, 1'b0);
    chk("br_load", 32'(is_br_out), 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush at occupancy 3 with a write pending; then a flush while empty.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h4004 + 32'(4 * i), 32'h200 + 32'(i), 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'h3);
    cyc(1'b1, 32'h4010, 32'h203, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_discard", 32'(discard_cnt), 32'h1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("flush_empty_discard", 32'(discard_cnt), 32'h1);

    // Flush while full with decode ready: no read completes.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h5004 + 32'(4 * i), 32'h300 + 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("flush_full_count", 32'(count), 32'h0);
    chk("flush_full_pc_we", 32'(pc_we), 32'h1);
    chk("flush_full_discard", 32'(discard_cnt), 32'h2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ins = $urandom();
      if ($urandom_range(0, 3) == 0) ins[31:27] = 5'b10100;
      cyc($urandom_range(0, 3) != 0, $urandom(), ins,
          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    // Reset asserted mid-cycle with entries queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h6004 + 32'(4 * i), 32'h400 + 32'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_instr", instr_out, 32'h0);
    chk("midrst_pc_we", 32'(pc_we), 32'h1);
    chk("midrst_discard", 32'(discard_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
